// File: rtl/ddr4_cmd_scheduler.sv
// DDR4 command scheduler. Tracks open rows per bank, issues PRE/ACT/RD/WR and
// periodic PREA+REF, and enforces command spacing while honouring DIMM stall.
module ddr4_cmd_scheduler #(
  parameter int BGWIDTH   = 2,
  parameter int BAWIDTH   = 2,
  parameter int ADDRWIDTH = 17,
  parameter int COLWIDTH  = 10,
  parameter int TRCD      = 4,
  parameter int TRP       = 4,
  parameter int TCCD      = 4,
  parameter int TRFC      = 32,
  parameter int TREFI     = 1000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_wr,
  input  logic [BGWIDTH-1:0]   req_bg,
  input  logic [BAWIDTH-1:0]   req_ba,
  input  logic [ADDRWIDTH-1:0] req_row,
  input  logic [COLWIDTH-1:0]  req_col,
  input  logic                 stall,
  output logic                 cke,
  output logic                 cs_n,
  output logic                 act_n,
  output logic [ADDRWIDTH-1:0] A,
  output logic [BGWIDTH-1:0]   bg,
  output logic [BAWIDTH-1:0]   ba,
  output logic                 cas_done,
  output logic                 cas_wr
);

  localparam int BANKW  = BGWIDTH + BAWIDTH;
  localparam int NBANKS = 1 << BANKW;

  typedef enum logic [2:0] {
    S_IDLE, S_PRE, S_ACT, S_CAS, S_PREA, S_REF, S_WAIT
  } state_t;

  state_t                 state;
  state_t                 after_wait;
  state_t                 cur;
  logic [7:0]             wait_cnt;
  logic [15:0]            ref_cnt;
  logic                   ref_pending;
  logic                   ref_expire;
  logic                   ref_pending_nxt;
  logic                   handshake;

  logic                   lat_wr;
  logic [BGWIDTH-1:0]     lat_bg;
  logic [BAWIDTH-1:0]     lat_ba;
  logic [ADDRWIDTH-1:0]   lat_row;
  logic [COLWIDTH-1:0]    lat_col;
  logic [BANKW-1:0]       lat_bank;
  logic [BANKW-1:0]       req_bank;

  logic [NBANKS-1:0]      bank_open;
  logic [ADDRWIDTH-1:0]   open_row [NBANKS];

  // Command word: ras_n/cas_n/we_n on A16..A14, A10 for all-bank precharge.
  function automatic logic [ADDRWIDTH-1:0] cmd_code(input logic [2:0] rcw,
                                                    input logic a10,
                                                    input logic [COLWIDTH-1:0] col);
    logic [ADDRWIDTH-1:0] a;
    a = '0;
    a[COLWIDTH-1:0] = col;
    a[10] = a10;
    a[16:14] = rcw;
    return a;
  endfunction

  // A WAIT whose counter has run out behaves as the following command state
  // in the same cycle, so a spacing of T puts commands exactly T cycles apart.
  assign cur = (state == S_WAIT && wait_cnt == 8'd0) ? after_wait : state;

  assign req_bank        = {req_bg, req_ba};
  assign lat_bank        = {lat_bg, lat_ba};
  assign ref_expire      = (ref_cnt == 16'(TREFI - 1));
  assign ref_pending_nxt = ref_expire || (ref_pending && !(cur == S_REF && !stall));
  assign handshake       = (cur == S_IDLE) && req_valid && req_ready;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= S_IDLE;
      after_wait  <= S_IDLE;
      wait_cnt    <= '0;
      ref_cnt     <= '0;
      ref_pending <= 1'b0;
      bank_open   <= '0;
      lat_wr      <= 1'b0;
      lat_bg      <= '0;
      lat_ba      <= '0;
      lat_row     <= '0;
      lat_col     <= '0;
      cke         <= 1'b0;
      cs_n        <= 1'b1;
      act_n       <= 1'b1;
      A           <= '0;
      bg          <= '0;
      ba          <= '0;
      req_ready   <= 1'b0;
      cas_done    <= 1'b0;
      cas_wr      <= 1'b0;
    end else begin
      cke         <= 1'b1;
      cs_n        <= 1'b1;
      act_n       <= 1'b1;
      cas_done    <= 1'b0;
      cas_wr      <= 1'b0;
      req_ready   <= 1'b0;
      ref_pending <= ref_pending_nxt;
      ref_cnt     <= ref_expire ? 16'd0 : ref_cnt + 16'd1;
      state       <= cur;
      if (state == S_WAIT && wait_cnt != 8'd0)
        wait_cnt <= wait_cnt - 8'd1;

      case (cur)
        S_IDLE: begin
          if (handshake) begin
            lat_wr  <= req_wr;
            lat_bg  <= req_bg;
            lat_ba  <= req_ba;
            lat_row <= req_row;
            lat_col <= req_col;
            if (bank_open[req_bank] && open_row[req_bank] == req_row)
              state <= S_CAS;
            else if (bank_open[req_bank])
              state <= S_PRE;
            else
              state <= S_ACT;
          end else if (ref_pending) begin
            state <= S_PREA;
          end else begin
            req_ready <= !stall && !ref_pending_nxt;
          end
        end

        S_PRE: if (!stall) begin
          cs_n                <= 1'b0;
          A                   <= cmd_code(3'b010, 1'b0, '0);
          bg                  <= lat_bg;
          ba                  <= lat_ba;
          bank_open[lat_bank] <= 1'b0;
          state               <= S_WAIT;
          after_wait          <= S_ACT;
          wait_cnt            <= 8'(TRP - 1);
        end

        S_ACT: if (!stall) begin
          cs_n                <= 1'b0;
          act_n               <= 1'b0;
          A                   <= lat_row;
          bg                  <= lat_bg;
          ba                  <= lat_ba;
          bank_open[lat_bank] <= 1'b1;
          state               <= S_WAIT;
          after_wait          <= S_CAS;
          wait_cnt            <= 8'(TRCD - 1);
        end

        S_CAS: if (!stall) begin
          cs_n       <= 1'b0;
          A          <= cmd_code(lat_wr ? 3'b100 : 3'b101, 1'b0, lat_col);
          bg         <= lat_bg;
          ba         <= lat_ba;
          cas_done   <= 1'b1;
          cas_wr     <= lat_wr;
          state      <= S_WAIT;
          after_wait <= S_IDLE;
          wait_cnt   <= 8'(TCCD - 1);
        end

        S_PREA: if (!stall) begin
          cs_n       <= 1'b0;
          A          <= cmd_code(3'b010, 1'b1, '0);
          bg         <= '0;
          ba         <= '0;
          bank_open  <= '0;
          state      <= S_WAIT;
          after_wait <= S_REF;
          wait_cnt   <= 8'(TRP - 1);
        end

        S_REF: if (!stall) begin
          cs_n       <= 1'b0;
          A          <= cmd_code(3'b001, 1'b0, '0);
          bg         <= '0;
          ba         <= '0;
          state      <= S_WAIT;
          after_wait <= S_IDLE;
          wait_cnt   <= 8'(TRFC - 1);
        end

        default: ;
      endcase
    end
  end

  // Row storage needs no reset: it is only consulted while the open bit is set.
  always_ff @(posedge clk) begin
    if (reset_n && cur == S_ACT && !stall)
      open_row[lat_bank] <= lat_row;
  end

endmodule
